// File: rtl/enable_seq_pkg.sv
// Shared types and constants for the cross-domain enable sequencer.
package enable_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_e;

  localparam logic MODE_NESTED = 1'b0;  // all on, drop lowest first
  localparam logic MODE_ONEHOT = 1'b1;  // single enable walks upward

endpackage

// File: rtl/toggle_sync.sv
// Toggle-to-pulse synchroniser: a flop chain in the destination clock followed by an
// edge-detect flop; every source toggle becomes one destination-cycle pulse.
module toggle_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tgl_in,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Synchroniser chain plus the last-seen value for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tgl_in};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] ^ last_q;

endmodule

// File: rtl/enable_sequencer.sv
// Cross-domain enable sequencer: a clkA trigger launches a staggered enable sequence in
// clkB; completion returns to clkA. Both directions use toggle handshakes.
module enable_sequencer
  import enable_seq_pkg::*;
#(
  parameter int unsigned N_EN        = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_W      = 4
) (
  input  logic              clkA,
  input  logic              rst_n,
  input  logic              clkB,
  input  logic              trg,
  input  logic              mode,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic              busy_A,
  output logic              done_A,
  output logic [N_EN-1:0]   ena,
  output logic              active_B
);

  localparam int unsigned StepW = $clog2(N_EN);
  localparam logic [StepW-1:0] LastStep = StepW'(N_EN - 1);

  // ---------------- clkA domain ----------------
  logic trg_q, req_tgl, busy_q, done_q, ack_pulse;

  // Trigger edge detect, request launch and completion pulse.
  always_ff @(posedge clkA or negedge rst_n) begin
    if (!rst_n) begin
      trg_q   <= 1'b0;
      req_tgl <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      trg_q  <= trg;
      done_q <= 1'b0;
      if (ack_pulse && busy_q) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end else if (trg && !trg_q && !busy_q) begin
        // Edges seen while busy are dropped, not queued.
        req_tgl <= ~req_tgl;
        busy_q  <= 1'b1;
      end
    end
  end

  assign busy_A = busy_q;
  assign done_A = done_q;

  // ---------------- clkB domain ----------------
  logic              req_pulse, ack_tgl;
  seq_state_e        state_q;
  logic              mode_q, active_q;
  logic [HOLD_W-1:0] hold_lim_q, hold_q;
  logic [StepW-1:0]  step_q, step_nxt;
  logic [N_EN-1:0]   ena_q;

  assign step_nxt = step_q + StepW'(1);

  function automatic logic [N_EN-1:0] pattern(input logic m, input logic [StepW-1:0] k);
    logic [N_EN-1:0] p;
    p = '0;
    for (int i = 0; i < int'(N_EN); i++) begin
      p[i] = (m == MODE_ONEHOT) ? (i == int'(k)) : (i >= int'(k));
    end
    return p;
  endfunction

  // Sequencer FSM with registered enables; a req pulse outside IDLE is ignored.
  always_ff @(posedge clkB or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= MODE_NESTED;
      hold_lim_q <= '0;
      hold_q     <= '0;
      step_q     <= '0;
      ena_q      <= '0;
      active_q   <= 1'b0;
      ack_tgl    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_pulse) begin
            mode_q     <= mode;
            hold_lim_q <= hold_cycles;
            hold_q     <= '0;
            step_q     <= '0;
            ena_q      <= pattern(mode, '0);
            active_q   <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (hold_q == hold_lim_q) begin
            hold_q <= '0;
            if (step_q == LastStep) begin
              ena_q   <= '0;
              state_q <= DONE;
            end else begin
              step_q <= step_nxt;
              ena_q  <= pattern(mode_q, step_nxt);
            end
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        DONE: begin
          ena_q    <= '0;
          active_q <= 1'b0;
          ack_tgl  <= ~ack_tgl;
          state_q  <= IDLE;
        end
        default: begin
          ena_q    <= '0;
          active_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign ena      = ena_q;
  assign active_B = active_q;

  // ---------------- crossings ----------------
  toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk   (clkB),
    .rst_n (rst_n),
    .tgl_in(req_tgl),
    .pulse (req_pulse)
  );

  toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clkA),
    .rst_n (rst_n),
    .tgl_in(ack_tgl),
    .pulse (ack_pulse)
  );

endmodule

// File: tb/tb_enable_sequencer.sv
// Directed bench for enable_sequencer: sequence shape, drop/retrigger rules, clock
// ratios and mid-run reset.
module tb_enable_sequencer;

  localparam int N_EN = 3;

  logic            clkA = 1'b0, clkB = 1'b0, rst_n = 1'b0, trg = 1'b0, mode = 1'b0;
  logic [3:0]      hold_cycles = 4'd0;
  logic            busy_A, done_A, active_B;
  logic [N_EN-1:0] ena;

  int ha = 5, hb = 5, skip_a = 0, skip_b = 0;
  int errors = 0, checks = 0;
  int done_cnt = 0, idle_viol = 0;
  logic [N_EN-1:0] log_q[$];
  logic [N_EN-1:0] exp_q[$];

  enable_sequencer #(
    .N_EN       (N_EN),
    .SYNC_STAGES(2),
    .HOLD_W     (4)
  ) dut (
    .clkA       (clkA),
    .rst_n      (rst_n),
    .clkB       (clkB),
    .trg        (trg),
    .mode       (mode),
    .hold_cycles(hold_cycles),
    .busy_A     (busy_A),
    .done_A     (done_A),
    .ena        (ena),
    .active_B   (active_B)
  );

  initial forever begin
    #(ha);
    if (skip_a > 0) begin #(skip_a); skip_a = 0; end
    clkA = ~clkA;
  end

  initial forever begin
    #(hb);
    if (skip_b > 0) begin #(skip_b); skip_b = 0; end
    clkB = ~clkB;
  end

  always @(negedge clkA) if (rst_n && done_A) done_cnt++;

  // Record ena every clkB cycle the sequencer is active; ena must be 0 otherwise.
  always @(negedge clkB) begin
    if (rst_n) begin
      if (active_B) log_q.push_back(ena);
      else if (ena != '0) idle_viol++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic push_step(input logic [N_EN-1:0] p, input int n);
    repeat (n) exp_q.push_back(p);
  endtask

  task automatic pulse_trg();
    @(negedge clkA);
    trg = 1'b1;
    @(negedge clkA);
    trg = 1'b0;
  endtask

  task automatic wait_done(input int start, input string tag);
    int n = 0;
    while (done_cnt == start && n < 3000) begin
      @(negedge clkA);
      n++;
    end
    check_eq({tag, "_no_timeout"}, 32'(done_cnt != start), 32'd1);
  endtask

  task automatic settle();
    repeat (20) @(negedge clkB);
    repeat (20) @(negedge clkA);
  endtask

  task automatic check_log(input string tag);
    check_eq({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check_eq($sformatf("%s_ena%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
  endtask

  task automatic run_seq(input string tag, input logic m, input logic [3:0] h, input bit extra);
    int d0;
    @(negedge clkA);
    mode = m;
    hold_cycles = h;
    d0 = done_cnt;
    log_q.delete();
    pulse_trg();
    if (extra) begin
      repeat (2) @(negedge clkA);
      check_eq({tag, "_busy_mid"}, 32'(busy_A), 32'd1);
      pulse_trg();
    end
    wait_done(d0, tag);
    settle();
    check_eq({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    check_eq({tag, "_busy_after"}, 32'(busy_A), 32'd0);
    check_log(tag);
  endtask

  initial begin
    int d0, n;

    // Reset state
    #3;
    check_eq("rst_busy", 32'(busy_A), 32'd0);
    check_eq("rst_done", 32'(done_A), 32'd0);
    check_eq("rst_ena", 32'(ena), 32'd0);
    check_eq("rst_active", 32'(active_B), 32'd0);
    repeat (3) @(negedge clkA);
    rst_n = 1'b1;

    // 1: nested, 1-cycle steps
    exp_q.delete();
    push_step(3'b111, 1); push_step(3'b110, 1); push_step(3'b100, 1); push_step(3'b000, 1);
    run_seq("t1", 1'b0, 4'd0, 1'b0);

    // 2: one-hot, 3-cycle steps, active_B for 10 cycles
    exp_q.delete();
    push_step(3'b001, 3); push_step(3'b010, 3); push_step(3'b100, 3); push_step(3'b000, 1);
    run_seq("t2", 1'b1, 4'd2, 1'b0);
    check_eq("t2_active_cycles", 32'(log_q.size()), 32'd10);

    // 3: second trigger while busy is dropped
    exp_q.delete();
    push_step(3'b111, 1); push_step(3'b110, 1); push_step(3'b100, 1); push_step(3'b000, 1);
    run_seq("t3", 1'b0, 4'd0, 1'b1);

    // 4: clock ratios with random phase
    exp_q.delete();
    push_step(3'b001, 3); push_step(3'b010, 3); push_step(3'b100, 3); push_step(3'b000, 1);
    ha = 5;  hb = 15; skip_b = $urandom_range(1, 9); run_seq("t4_1to3", 1'b1, 4'd2, 1'b0);
    ha = 15; hb = 5;  skip_a = $urandom_range(1, 9); run_seq("t4_3to1", 1'b1, 4'd2, 1'b0);
    ha = 7;  hb = 7;  skip_b = $urandom_range(1, 6); run_seq("t4_1to1", 1'b1, 4'd2, 1'b0);
    ha = 5;  hb = 5;

    // 5: reset during step 1, then a full run
    @(negedge clkA);
    mode = 1'b0;
    hold_cycles = 4'd3;
    pulse_trg();
    n = 0;
    while (ena !== 3'b110 && n < 200) begin
      @(negedge clkB);
      n++;
    end
    check_eq("t5_reached_step1", 32'(ena), 32'h6);
    d0 = done_cnt;
    #1 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_ena", 32'(ena), 32'd0);
    check_eq("t5_rst_busy", 32'(busy_A), 32'd0);
    check_eq("t5_rst_active", 32'(active_B), 32'd0);
    repeat (3) @(negedge clkA);
    rst_n = 1'b1;
    settle();
    check_eq("t5_no_done", 32'(done_cnt - d0), 32'd0);
    exp_q.delete();
    push_step(3'b111, 4); push_step(3'b110, 4); push_step(3'b100, 4); push_step(3'b000, 1);
    run_seq("t5_rerun", 1'b0, 4'd3, 1'b0);

    // 6a: trigger held high across completion never retriggers
    @(negedge clkA);
    mode = 1'b0;
    hold_cycles = 4'd0;
    d0 = done_cnt;
    trg = 1'b1;
    wait_done(d0, "t6a");
    settle();
    check_eq("t6a_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_eq("t6a_busy", 32'(busy_A), 32'd0);
    @(negedge clkA);
    trg = 1'b0;

    // 6b: trigger edge in the done_A cycle is accepted
    d0 = done_cnt;
    pulse_trg();
    n = 0;
    while (done_A !== 1'b1 && n < 3000) begin
      @(negedge clkA);
      n++;
    end
    check_eq("t6b_done_seen", 32'(done_A), 32'd1);
    check_eq("t6b_busy_in_done", 32'(busy_A), 32'd0);
    trg = 1'b1;
    @(negedge clkA);
    check_eq("t6b_accept", 32'(busy_A), 32'd1);
    trg = 1'b0;
    log_q.delete();
    wait_done(d0 + 1, "t6b");
    settle();
    check_eq("t6b_done_cnt", 32'(done_cnt - d0), 32'd2);
    exp_q.delete();
    push_step(3'b111, 1); push_step(3'b110, 1); push_step(3'b100, 1); push_step(3'b000, 1);
    check_log("t6b");

    check_eq("ena_zero_when_inactive", 32'(idle_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
